// File: rtl/mcbsp_frame_tx_pkg.sv
// Shared types and defaults for the downlink McBSP frame transmitter.
// The optional checksum byte is enabled with the MCBSP_TX_CHECKSUM_EN macro.
package mcbsp_frame_tx_pkg;

    localparam int BYTE_W      = 8;
    localparam int LEN_W       = 8;
    localparam int SYNC_W      = 16;
    localparam int CLK_DIV_DEF = 2;

    localparam logic [SYNC_W-1:0] SYNC_WORD_DEF = 16'hEB90;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SYNC,
        LEN,
        PAYLOAD,
        CHK,
        GAP
    } state_t;

endpackage

// File: rtl/mcbsp_tx_fifo.sv
// Single-clock byte FIFO with first-word fall-through read data.
// Holds one frame of payload between the downlink data path and the serialiser.
module mcbsp_tx_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign w_do_wr = i_wr_en && !o_full;
    assign w_do_rd = i_rd_en && !o_empty;

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);

endmodule

// File: rtl/mcbsp_frame_tx.sv
// Buffers one downlink payload frame and shifts it to the DSP as FSX/ClkX/DX McBSP framing.
// Define MCBSP_TX_CHECKSUM_EN to append an 8-bit (LEN + payload) checksum byte after the payload.
module mcbsp_frame_tx
    import mcbsp_frame_tx_pkg::*;
#(
    parameter int                CLK_DIV   = CLK_DIV_DEF,
    parameter int                MAX_LEN   = 64,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int                GAP_BITS  = 4
) (
    input  logic              Clk10MHz,
    input  logic              Rst,
    input  logic              LinkEnable,
    input  logic [BYTE_W-1:0] TxData,
    input  logic              TxValid,
    input  logic              TxLast,
    output logic              TxReady,
    output logic              McBSPClkX,
    output logic              McBSPFSX,
    output logic              McBSPDX,
    output logic              TxBusy,
    output logic              FrameDone,
    output logic              TruncErr
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [DIV_W-1:0]  r_div;
    logic [SYNC_W-1:0] r_sh;
    logic [7:0]        r_bitcnt;
    logic              r_fsx;
    logic              r_dx;
    logic              r_done;
    logic              r_trunc;

    logic              w_ready;
    logic              w_hs;
    logic              w_serial;
    logic              w_tick;
    logic              w_field_end;
    logic              w_at_max;
    logic              w_wr;
    logic              w_rd;
    logic              w_close;
    logic              w_trunc;
    logic              w_done;
    logic              w_load_byte;
    logic [BYTE_W-1:0] w_load_val;

    logic [BYTE_W-1:0] w_rd_data;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;

`ifdef MCBSP_TX_CHECKSUM_EN
    logic [BYTE_W-1:0] r_chk;
`endif

    mcbsp_tx_fifo #(
        .DEPTH (MAX_LEN),
        .WIDTH (BYTE_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk     (Clk10MHz),
        .i_rst     (Rst),
        .i_wr_en   (w_wr),
        .i_wr_data (TxData),
        .i_rd_en   (w_rd),
        .o_rd_data (w_rd_data),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_serial    = r_state inside {SYNC, LEN, PAYLOAD, CHK, GAP};
    assign w_tick      = w_serial && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_field_end = w_tick && (r_bitcnt == '0);
    assign w_ready     = ((r_state == IDLE) && LinkEnable) || ((r_state == FILL) && !w_full);
    assign w_hs        = TxValid && w_ready;
    assign w_at_max    = (w_count == CNT_W'(MAX_LEN - 1));

    always_ff @(posedge Clk10MHz) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_wr         = 1'b0;
        w_rd         = 1'b0;
        w_close      = 1'b0;
        w_trunc      = 1'b0;
        w_done       = 1'b0;
        w_load_byte  = 1'b0;
        w_load_val   = '0;
        unique case (r_state)
            IDLE, FILL: begin
                if (w_hs) begin
                    w_wr = 1'b1;
                    if (TxLast || w_at_max) begin
                        w_close      = 1'b1;
                        w_trunc      = !TxLast;
                        w_state_next = SYNC;
                    end else begin
                        w_state_next = FILL;
                    end
                end
            end
            SYNC: begin
                if (w_field_end) begin
                    w_state_next = LEN;
                    w_load_byte  = 1'b1;
                    w_load_val   = LEN_W'(w_count);
                end
            end
            LEN: begin
                if (w_field_end) begin
                    w_state_next = PAYLOAD;
                    w_rd         = 1'b1;
                    w_load_byte  = 1'b1;
                    w_load_val   = w_rd_data;
                end
            end
            PAYLOAD: begin
                if (w_field_end) begin
                    if (!w_empty) begin
                        w_rd        = 1'b1;
                        w_load_byte = 1'b1;
                        w_load_val  = w_rd_data;
                    end else begin
`ifdef MCBSP_TX_CHECKSUM_EN
                        w_state_next = CHK;
                        w_load_byte  = 1'b1;
                        w_load_val   = r_chk;
`else
                        w_state_next = GAP;
`endif
                    end
                end
            end
            CHK: begin
                if (w_field_end) begin
                    w_state_next = GAP;
                end
            end
            GAP: begin
                if (w_field_end) begin
                    w_state_next = IDLE;
                    w_done       = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // r_bitcnt holds the bits still to follow the one currently driven on DX.
    always_ff @(posedge Clk10MHz) begin
        if (Rst) begin
            r_div    <= '0;
            r_sh     <= '0;
            r_bitcnt <= '0;
            r_fsx    <= 1'b0;
            r_dx     <= 1'b0;
            r_done   <= 1'b0;
            r_trunc  <= 1'b0;
        end else begin
            r_done  <= w_done;
            r_trunc <= w_trunc;
            r_div   <= (!w_serial || w_tick) ? '0 : r_div + 1'b1;
            if (w_close) begin
                r_fsx    <= 1'b1;
                r_dx     <= 1'b0;
                r_sh     <= SYNC_WORD;
                r_bitcnt <= 8'(SYNC_W);
            end else if (w_tick) begin
                r_fsx <= 1'b0;
                if (r_bitcnt != '0) begin
                    r_dx     <= r_sh[SYNC_W-1];
                    r_sh     <= {r_sh[SYNC_W-2:0], 1'b0};
                    r_bitcnt <= r_bitcnt - 1'b1;
                end else if (w_load_byte) begin
                    r_dx     <= w_load_val[BYTE_W-1];
                    r_sh     <= {w_load_val[BYTE_W-2:0], (SYNC_W - BYTE_W + 1)'(0)};
                    r_bitcnt <= 8'(BYTE_W - 1);
                end else begin
                    r_dx     <= 1'b0;
                    r_sh     <= '0;
                    r_bitcnt <= (w_state_next == GAP) ? 8'(GAP_BITS - 1) : '0;
                end
            end
        end
    end

`ifdef MCBSP_TX_CHECKSUM_EN
    always_ff @(posedge Clk10MHz) begin
        if (Rst || w_close) begin
            r_chk <= '0;
        end else if (w_field_end && (r_state == SYNC)) begin
            r_chk <= r_chk + LEN_W'(w_count);
        end else if (w_rd) begin
            r_chk <= r_chk + w_rd_data;
        end
    end
`endif

    assign TxReady   = w_ready;
    assign McBSPClkX = w_serial && (r_div >= DIV_W'(CLK_DIV / 2));
    assign McBSPFSX  = r_fsx;
    assign McBSPDX   = r_dx;
    assign TxBusy    = w_serial;
    assign FrameDone = r_done;
    assign TruncErr  = r_trunc;

endmodule

// File: tb/tb_mcbsp_frame_tx.sv
// Directed self-checking bench for mcbsp_frame_tx: decodes the McBSP stream on ClkX rising edges.
// Expected checksum bytes and timing follow MCBSP_TX_CHECKSUM_EN when the bench is built with it.
module tb_mcbsp_frame_tx;

    localparam int CLK_DIV  = 2;
    localparam int MAX_LEN  = 64;
    localparam int GAP_BITS = 4;
`ifdef MCBSP_TX_CHECKSUM_EN
    localparam int CHK_BITS = 8;
`else
    localparam int CHK_BITS = 0;
`endif

    logic       Clk10MHz = 1'b0;
    logic       Rst = 1'b1;
    logic       LinkEnable = 1'b0;
    logic [7:0] TxData = 8'h00;
    logic       TxValid = 1'b0;
    logic       TxLast = 1'b0;
    logic       TxReady, McBSPClkX, McBSPFSX, McBSPDX, TxBusy, FrameDone, TruncErr;

    int n_assert = 0;
    int n_fail   = 0;

    // Receiver/monitor state
    int   cyc = 0;
    int   fsx_rise_cyc = 0;
    int   fsx_hi = 0;
    int   done_cyc = 0;
    int   done_count = 0;
    int   trunc_count = 0;
    bit   in_frame = 0;
    logic prev_fsx = 1'b0;
    logic prev_clkx = 1'b0;
    logic bitq[$];
    logic last_frame[$];

    mcbsp_frame_tx #(
        .CLK_DIV   (CLK_DIV),
        .MAX_LEN   (MAX_LEN),
        .SYNC_WORD (16'hEB90),
        .GAP_BITS  (GAP_BITS)
    ) dut (
        .Clk10MHz   (Clk10MHz),
        .Rst        (Rst),
        .LinkEnable (LinkEnable),
        .TxData     (TxData),
        .TxValid    (TxValid),
        .TxLast     (TxLast),
        .TxReady    (TxReady),
        .McBSPClkX  (McBSPClkX),
        .McBSPFSX   (McBSPFSX),
        .McBSPDX    (McBSPDX),
        .TxBusy     (TxBusy),
        .FrameDone  (FrameDone),
        .TruncErr   (TruncErr)
    );

    always #50 Clk10MHz = ~Clk10MHz;

    always @(negedge Clk10MHz) begin
        cyc++;
        if (McBSPFSX && !prev_fsx) begin
            fsx_rise_cyc = cyc;
            fsx_hi = 0;
        end
        if (McBSPFSX) fsx_hi++;
        if (McBSPClkX && !prev_clkx) begin
            if (McBSPFSX) begin
                bitq.delete();
                in_frame = 1;
            end else if (in_frame) begin
                bitq.push_back(McBSPDX);
            end
        end
        if (FrameDone) begin
            done_count++;
            done_cyc = cyc;
            last_frame = bitq;
            in_frame = 0;
        end
        if (TruncErr) trunc_count++;
        prev_fsx  = McBSPFSX;
        prev_clkx = McBSPClkX;
    end

    function automatic logic [7:0] fbyte(input int idx);
        logic [7:0] v = 8'h00;
        for (int b = 0; b < 8; b++) v = {v[6:0], last_frame[idx*8+b]};
        return v;
    endfunction

    function automatic logic [GAP_BITS-1:0] fgap(input int nbytes);
        logic [GAP_BITS-1:0] v = '0;
        for (int b = 0; b < GAP_BITS; b++) v = {v[GAP_BITS-2:0], last_frame[nbytes*8+b]};
        return v;
    endfunction

    task automatic push_byte(input logic [7:0] d, input logic last, output bit ok);
        TxData  = d;
        TxLast  = last;
        TxValid = 1'b1;
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            #1;
            if (TxReady) begin
                ok = 1;
                @(negedge Clk10MHz);
                break;
            end
            @(negedge Clk10MHz);
        end
        TxValid = 1'b0;
        TxLast  = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge Clk10MHz);
            #1;
            if (done_count > base) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit seen = 0;
        Rst = 1'b1; LinkEnable = 1'b0; TxValid = 1'b1; TxData = 8'h77;
        repeat (3) @(negedge Clk10MHz);
        n_assert++;
        if ({TxReady, McBSPClkX, McBSPFSX, McBSPDX, TxBusy, FrameDone, TruncErr} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {TxReady, McBSPClkX, McBSPFSX, McBSPDX, TxBusy, FrameDone, TruncErr});
        end
        Rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk10MHz);
            #1;
            if (TxReady || McBSPClkX || McBSPFSX || TxBusy) seen = 1;
        end
        n_assert++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_link: activity seen=%0d expected 0", seen);
        end
        TxValid = 1'b0;
        n_assert++;
        if (done_count !== 0) begin
            n_fail++;
            $display("FAIL idle_no_done: done_count=%0d expected 0", done_count);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp[$];
        bit ok0, ok1, ok2, okd;
        int base = done_count;
        LinkEnable = 1'b1;
        @(negedge Clk10MHz);
        push_byte(8'h12, 1'b0, ok0);
        push_byte(8'h34, 1'b0, ok1);
        push_byte(8'h56, 1'b1, ok2);
        n_assert++;
        if (!(ok0 && ok1 && ok2)) begin
            n_fail++;
            $display("FAIL basic_handshake: ok=%0d%0d%0d expected 111", ok0, ok1, ok2);
        end
        n_assert++;
        if (TxReady !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ready_after_last: got %b expected 0", TxReady);
        end
        wait_done(base, 600, okd);
        n_assert++;
        if (!okd) begin
            n_fail++;
            $display("FAIL basic_done_timeout: got none expected FrameDone");
        end
        exp = '{8'hEB, 8'h90, 8'h03, 8'h12, 8'h34, 8'h56};
`ifdef MCBSP_TX_CHECKSUM_EN
        exp.push_back(8'h9F);
`endif
        n_assert++;
        if (fsx_hi !== CLK_DIV) begin
            n_fail++;
            $display("FAIL basic_fsx_width: got %0d expected %0d", fsx_hi, CLK_DIV);
        end
        n_assert++;
        if (done_cyc - fsx_rise_cyc !== 2 * (1 + 16 + 8 + 24 + CHK_BITS + GAP_BITS)) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected %0d", done_cyc - fsx_rise_cyc,
                     2 * (1 + 16 + 8 + 24 + CHK_BITS + GAP_BITS));
        end
        n_assert++;
        if (last_frame.size() !== 8 * exp.size() + GAP_BITS) begin
            n_fail++;
            $display("FAIL basic_bitcount: got %0d expected %0d", last_frame.size(), 8 * exp.size() + GAP_BITS);
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_assert++;
            if (fbyte(i) !== exp[i]) begin
                n_fail++;
                $display("FAIL basic_byte%0d: got %h expected %h", i, fbyte(i), exp[i]);
            end
        end
        n_assert++;
        if (fgap(exp.size()) !== '0) begin
            n_fail++;
            $display("FAIL basic_gap: got %b expected 0", fgap(exp.size()));
        end
        repeat (10) @(negedge Clk10MHz);
        #1;
        n_assert++;
        if (done_count !== base + 1 || TxBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_single_done: done=%0d busy=%b expected %0d/0", done_count - base, TxBusy, 1);
        end
    endtask

    task automatic test_truncation();
        logic [7:0] sum = 8'h40;
        bit ok, okd;
        bit all_ok = 1;
        int base = done_count;
        int tbase = trunc_count;
        for (int i = 0; i < 63; i++) begin
            push_byte(8'(i), 1'b0, ok);
            if (!ok) all_ok = 0;
            sum = sum + 8'(i);
        end
        #1;
        n_assert++;
        if (trunc_count !== tbase || TxBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL trunc_early: trunc=%0d busy=%b expected 0/0", trunc_count - tbase, TxBusy);
        end
        push_byte(8'h3F, 1'b0, ok);
        if (!ok) all_ok = 0;
        sum = sum + 8'h3F;
        @(negedge Clk10MHz);
        #1;
        n_assert++;
        if (!all_ok || trunc_count !== tbase + 1) begin
            n_fail++;
            $display("FAIL trunc_pulse: hs_ok=%0d trunc=%0d expected 1/1", all_ok, trunc_count - tbase);
        end
        wait_done(base, 3000, okd);
        n_assert++;
        if (!okd || last_frame.size() !== 8 * (3 + 64) + CHK_BITS + GAP_BITS) begin
            n_fail++;
            $display("FAIL trunc_bitcount: done=%0d got %0d expected %0d", okd, last_frame.size(),
                     8 * (3 + 64) + CHK_BITS + GAP_BITS);
        end
        n_assert++;
        if (fbyte(2) !== 8'h40) begin
            n_fail++;
            $display("FAIL trunc_len: got %h expected 40", fbyte(2));
        end
        for (int i = 0; i < 64; i++) begin
            n_assert++;
            if (fbyte(3 + i) !== 8'(i)) begin
                n_fail++;
                $display("FAIL trunc_payload%0d: got %h expected %h", i, fbyte(3 + i), 8'(i));
            end
        end
`ifdef MCBSP_TX_CHECKSUM_EN
        n_assert++;
        if (fbyte(67) !== sum) begin
            n_fail++;
            $display("FAIL trunc_chk: got %h expected %h", fbyte(67), sum);
        end
`endif
        repeat (4) @(negedge Clk10MHz);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        bit ok0, ok1, got_ready, okd;
        int base = done_count;
        int q1_size;
        logic [7:0] q1_len;
        push_byte(8'hC3, 1'b0, ok0);
        push_byte(8'h3C, 1'b1, ok1);
        TxData = 8'h81; TxLast = 1'b1; TxValid = 1'b1;
        got_ready = 0;
        for (int k = 0; k < 600; k++) begin
            #1;
            if (TxReady) begin
                got_ready = 1;
                break;
            end
            @(negedge Clk10MHz);
        end
        n_assert++;
        if (!got_ready || done_count !== base + 1 || TxBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_hold: ready=%0d done=%0d busy=%b expected 1/1/0",
                     got_ready, done_count - base, TxBusy);
        end
        q1_size = last_frame.size();
        q1_len  = fbyte(2);
        @(negedge Clk10MHz);
        TxValid = 1'b0; TxLast = 1'b0;
        n_assert++;
        if (!(ok0 && ok1) || q1_size !== 8 * 5 + CHK_BITS + GAP_BITS || q1_len !== 8'h02) begin
            n_fail++;
            $display("FAIL b2b_first_frame: ok=%0d%0d bits=%0d len=%h expected 11/%0d/02",
                     ok0, ok1, q1_size, q1_len, 8 * 5 + CHK_BITS + GAP_BITS);
        end
        wait_done(base + 1, 600, okd);
        exp = '{8'hEB, 8'h90, 8'h01, 8'h81};
`ifdef MCBSP_TX_CHECKSUM_EN
        exp.push_back(8'h82);
`endif
        n_assert++;
        if (!okd || last_frame.size() !== 8 * exp.size() + GAP_BITS) begin
            n_fail++;
            $display("FAIL b2b_second_bits: done=%0d got %0d expected %0d", okd, last_frame.size(),
                     8 * exp.size() + GAP_BITS);
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_assert++;
            if (fbyte(i) !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_byte%0d: got %h expected %h", i, fbyte(i), exp[i]);
            end
        end
        repeat (4) @(negedge Clk10MHz);
    endtask

    task automatic test_reset_mid_payload();
        logic [7:0] exp[$];
        bit ok0, ok1, ok2, ok3, okd;
        int base;
        push_byte(8'h11, 1'b0, ok0);
        push_byte(8'h22, 1'b0, ok1);
        push_byte(8'h33, 1'b1, ok2);
        for (int k = 0; k < 400 && bitq.size() < 30; k++) @(negedge Clk10MHz);
        n_assert++;
        if (bitq.size() < 30 || TxBusy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_reach_payload: bits=%0d busy=%b expected >=30/1", bitq.size(), TxBusy);
        end
        @(negedge Clk10MHz);
        Rst = 1'b1; LinkEnable = 1'b0;
        @(negedge Clk10MHz);
        n_assert++;
        if ({TxReady, McBSPClkX, McBSPFSX, McBSPDX, TxBusy, FrameDone, TruncErr} !== 7'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %b expected 0000000",
                     {TxReady, McBSPClkX, McBSPFSX, McBSPDX, TxBusy, FrameDone, TruncErr});
        end
        Rst = 1'b0; LinkEnable = 1'b1;
        base = done_count;
        repeat (20) @(negedge Clk10MHz);
        #1;
        n_assert++;
        if (done_count !== base || TxBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_completion: done=%0d busy=%b expected 0/0", done_count - base, TxBusy);
        end
        push_byte(8'hA5, 1'b1, ok3);
        wait_done(base, 400, okd);
        exp = '{8'hEB, 8'h90, 8'h01, 8'hA5};
`ifdef MCBSP_TX_CHECKSUM_EN
        exp.push_back(8'hA6);
`endif
        n_assert++;
        if (!ok3 || !okd || last_frame.size() !== 8 * exp.size() + GAP_BITS) begin
            n_fail++;
            $display("FAIL rst_new_frame_bits: hs=%0d done=%0d got %0d expected %0d", ok3, okd,
                     last_frame.size(), 8 * exp.size() + GAP_BITS);
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_assert++;
            if (fbyte(i) !== exp[i]) begin
                n_fail++;
                $display("FAIL rst_new_byte%0d: got %h expected %h", i, fbyte(i), exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_back_to_back();
        test_reset_mid_payload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
